// File: rtl/apb_slave_regbank.sv
// APB completer: word-addressed register bank with per-transfer wait states,
// out-of-range error reporting and a saturating error counter.
module apb_slave_regbank #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned WAIT_WIDTH = 4
) (
    input  logic                  i_pclk,
    input  logic                  i_prst,
    input  logic                  i_psel,
    input  logic                  i_pen,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwr_data,
    input  logic [WAIT_WIDTH-1:0] i_wait_cfg,
    output logic                  o_pready,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pslver,
    output logic [7:0]            o_err_count
);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t                r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic                  r_write, w_write_d;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
    logic [WAIT_WIDTH-1:0] r_cnt, w_cnt_d;
    logic                  r_pready, w_pready_d;
    logic                  r_pslver, w_pslver_d;
    logic [DATA_WIDTH-1:0] r_prdata, w_prdata_d;
    logic [7:0]            r_err_count, w_err_count_d;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_err;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_idx;

    // Full-width compare so high address bits never alias onto a valid word.
    assign w_err = (32'(r_addr) >= MEM_DEPTH);
    assign w_idx = r_addr[IDX_W-1:0];

    always_comb begin
        w_state_d     = r_state;
        w_addr_d      = r_addr;
        w_write_d     = r_write;
        w_wdata_d     = r_wdata;
        w_cnt_d       = r_cnt;
        w_pready_d    = 1'b0;
        w_pslver_d    = 1'b0;
        w_prdata_d    = r_prdata;
        w_err_count_d = r_err_count;
        w_mem_we      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_psel && !i_pen) begin
                    w_addr_d  = i_paddr;
                    w_write_d = i_pwrite;
                    w_wdata_d = i_pwr_data;
                    w_cnt_d   = i_wait_cfg;
                    w_state_d = StAccess;
                end
            end
            StAccess: begin
                if (!i_psel) begin
                    w_state_d = StIdle;
                end else if (!i_pen) begin
                    w_cnt_d = r_cnt;
                end else if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - 1'b1;
                end else begin
                    w_pready_d = 1'b1;
                    w_pslver_d = w_err;
                    if (w_err) begin
                        if (!r_write) begin
                            w_prdata_d = '0;
                        end
                        if (r_err_count != 8'hFF) begin
                            w_err_count_d = r_err_count + 8'd1;
                        end
                    end else if (r_write) begin
                        w_mem_we = 1'b1;
                    end else begin
                        w_prdata_d = r_mem[w_idx];
                    end
                    w_state_d = StResp;
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_pready    <= 1'b0;
            r_pslver    <= 1'b0;
            r_prdata    <= '0;
            r_err_count <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_write     <= w_write_d;
            r_wdata     <= w_wdata_d;
            r_cnt       <= w_cnt_d;
            r_pready    <= w_pready_d;
            r_pslver    <= w_pslver_d;
            r_prdata    <= w_prdata_d;
            r_err_count <= w_err_count_d;
            if (w_mem_we) begin
                r_mem[w_idx] <= r_wdata;
            end
        end
    end

    assign o_pready    = r_pready;
    assign o_pslver    = r_pslver;
    assign o_prdata    = r_prdata;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: table of transfers plus abort, mid-transfer
// reset and error-counter saturation sequences.
module tb_apb_slave_regbank;
    logic        i_pclk = 1'b0;
    logic        i_prst;
    logic        i_psel;
    logic        i_pen;
    logic        i_pwrite;
    logic [15:0] i_paddr;
    logic [15:0] i_pwr_data;
    logic [3:0]  i_wait_cfg;
    logic        o_pready;
    logic [15:0] o_prdata;
    logic        o_pslver;
    logic [7:0]  o_err_count;

    int n_chk = 0;
    int n_err = 0;

    apb_slave_regbank #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .MEM_DEPTH (16),
        .WAIT_WIDTH(4)
    ) dut (
        .i_pclk     (i_pclk),
        .i_prst     (i_prst),
        .i_psel     (i_psel),
        .i_pen      (i_pen),
        .i_pwrite   (i_pwrite),
        .i_paddr    (i_paddr),
        .i_pwr_data (i_pwr_data),
        .i_wait_cfg (i_wait_cfg),
        .o_pready   (o_pready),
        .o_prdata   (o_prdata),
        .o_pslver   (o_pslver),
        .o_err_count(o_err_count)
    );

    always #5 i_pclk = ~i_pclk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  wt;
        logic        slv;
        logic [15:0] rd;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge with the DUT in IDLE; returns the same way, so
    // consecutive calls exercise back-to-back setups.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        input logic [3:0] wt, input logic exp_slv, input logic [15:0] exp_rd,
                        input logic [7:0] exp_err, input string tag);
        int  k;
        logic seen;
        i_psel     = 1'b1;
        i_pen      = 1'b0;
        i_pwrite   = wr;
        i_paddr    = addr;
        i_pwr_data = data;
        i_wait_cfg = wt;
        @(posedge i_pclk); #1;
        i_pen      = 1'b1;
        i_wait_cfg = ~wt;
        i_paddr    = addr ^ 16'h0003;
        i_pwr_data = ~data;
        k    = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge i_pclk); #1;
            if (o_pready) begin
                seen = 1'b1;
                k    = c;
            end
        end
        chk({tag, " latency"}, 32'(k), 32'(wt) + 32'd1);
        chk({tag, " pslver"}, 32'(o_pslver), 32'(exp_slv));
        chk({tag, " prdata"}, 32'(o_prdata), 32'(exp_rd));
        chk({tag, " err_count"}, 32'(o_err_count), 32'(exp_err));
        i_psel = 1'b0;
        i_pen  = 1'b0;
        @(posedge i_pclk); #1;
        chk({tag, " pready pulse"}, 32'(o_pready), 32'd0);
        chk({tag, " pslver pulse"}, 32'(o_pslver), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 16'd3,      16'h0000, 4'd0,  1'b0, 16'h0000, 8'd0};
        vecs[1]  = '{1'b1, 16'd5,      16'hA5A5, 4'd2,  1'b0, 16'h0000, 8'd0};
        vecs[2]  = '{1'b0, 16'd5,      16'h0000, 4'd0,  1'b0, 16'hA5A5, 8'd0};
        vecs[3]  = '{1'b1, 16'd16,     16'h1234, 4'd1,  1'b1, 16'hA5A5, 8'd1};
        vecs[4]  = '{1'b0, 16'd16,     16'h0000, 4'd0,  1'b1, 16'h0000, 8'd2};
        vecs[5]  = '{1'b0, 16'd0,      16'h0000, 4'd0,  1'b0, 16'h0000, 8'd2};
        vecs[6]  = '{1'b1, 16'h8000,   16'hFFFF, 4'd0,  1'b1, 16'h0000, 8'd3};
        vecs[7]  = '{1'b1, 16'd15,     16'hC3C3, 4'd5,  1'b0, 16'h0000, 8'd3};
        vecs[8]  = '{1'b1, 16'd0,      16'h1111, 4'd0,  1'b0, 16'h0000, 8'd3};
        vecs[9]  = '{1'b0, 16'd15,     16'h0000, 4'd1,  1'b0, 16'hC3C3, 8'd3};
        vecs[10] = '{1'b0, 16'd0,      16'h0000, 4'd3,  1'b0, 16'h1111, 8'd3};
        vecs[11] = '{1'b0, 16'hFFFF,   16'h0000, 4'd0,  1'b1, 16'h0000, 8'd4};
        vecs[12] = '{1'b0, 16'd5,      16'h0000, 4'd15, 1'b0, 16'hA5A5, 8'd4};

        i_prst = 1'b1; i_psel = 1'b0; i_pen = 1'b0; i_pwrite = 1'b0;
        i_paddr = '0; i_pwr_data = '0; i_wait_cfg = '0;
        repeat (3) @(posedge i_pclk);
        #1;
        chk("reset pready", 32'(o_pready), 32'd0);
        chk("reset pslver", 32'(o_pslver), 32'd0);
        chk("reset prdata", 32'(o_prdata), 32'd0);
        chk("reset err_count", 32'(o_err_count), 32'd0);
        i_prst = 1'b0;

        // Enable without a preceding setup must be ignored.
        i_psel = 1'b1; i_pen = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_pclk); #1;
            chk($sformatf("pen-in-idle pready c%0d", c), 32'(o_pready), 32'd0);
        end
        i_psel = 1'b0; i_pen = 1'b0;
        @(posedge i_pclk); #1;

        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].wt, vecs[i].slv,
                 vecs[i].rd, vecs[i].err, $sformatf("v%0d", i));
        end

        // Abort: master drops psel during ACCESS, pending write must not land.
        xfer(1'b1, 16'd2, 16'h7777, 4'd0, 1'b0, 16'hA5A5, 8'd4, "abort prewrite");
        i_psel = 1'b1; i_pen = 1'b0; i_pwrite = 1'b1;
        i_paddr = 16'd2; i_pwr_data = 16'hBEEF; i_wait_cfg = 4'd3;
        @(posedge i_pclk); #1;
        i_pen = 1'b1;
        @(posedge i_pclk); #1;
        chk("abort pready access", 32'(o_pready), 32'd0);
        i_psel = 1'b0; i_pen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_pclk); #1;
            chk($sformatf("abort pready c%0d", c), 32'(o_pready), 32'd0);
        end
        xfer(1'b0, 16'd2, 16'h0000, 4'd0, 1'b0, 16'h7777, 8'd4, "abort readback");

        // Reset while in ACCESS with cnt=2.
        i_psel = 1'b1; i_pen = 1'b0; i_pwrite = 1'b1;
        i_paddr = 16'd4; i_pwr_data = 16'h5555; i_wait_cfg = 4'd4;
        @(posedge i_pclk); #1;
        i_pen = 1'b1;
        repeat (2) @(posedge i_pclk);
        #1;
        i_prst = 1'b1;
        @(posedge i_pclk); #1;
        chk("midrst pready", 32'(o_pready), 32'd0);
        chk("midrst pslver", 32'(o_pslver), 32'd0);
        chk("midrst prdata", 32'(o_prdata), 32'd0);
        chk("midrst err_count", 32'(o_err_count), 32'd0);
        i_prst = 1'b0; i_psel = 1'b0; i_pen = 1'b0;
        xfer(1'b0, 16'd4, 16'h0000, 4'd0, 1'b0, 16'h0000, 8'd0, "midrst read4");
        xfer(1'b0, 16'd5, 16'h0000, 4'd0, 1'b0, 16'h0000, 8'd0, "midrst read5");

        // Error counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            xfer(1'b0, 16'h0100 + 16'(i), 16'h0000, 4'd0, 1'b1, 16'h0000,
                 8'((i + 1 > 255) ? 255 : i + 1), $sformatf("sat%0d", i));
        end
        chk("sat final", 32'(o_err_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
